fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the opcode controller.
- Owns the program counter (PC) and instruction register (IR), and fetches from instruction memory over a req/ack handshake.
- Presents Opcode and Operand to the controller, then applies the controller's returned IncPC, LoadPC and SelPC to compute the next PC.
- Sequences the fetch → execute → update phases so that each instruction is executed exactly once.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- INSTR_W, 12, instruction width: Opcode in [INSTR_W-1:INSTR_W-4], Operand in [ADDR_W-1:0].
- TIMEOUT_CYCLES, 15, fetch wait limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- CLB  in  1  reset; asynchronous, active-high.
- imem_req  out  1  fetch request, held high until ack.
- imem_addr  out  ADDR_W  fetch address, equal to PC.
- imem_rdata  in  INSTR_W  instruction word, valid when imem_ack=1.
- imem_ack  in  1  one-cycle acknowledge from instruction memory.
- IncPC  in  1  controller: advance PC.
- LoadPC  in  1  controller: load PC.
- SelPC  in  1  controller: 1 = load reg_target, 0 = load Operand.
- reg_target  in  ADDR_W  register-file value used for register jumps.
- Opcode  out  4  IR opcode field.
- Operand  out  ADDR_W  IR immediate field.
- instr_valid  out  1  one-cycle pulse: IR holds a new instruction for the controller.
- pc  out  ADDR_W  current PC.
- halted  out  1  high in HALT.
- fetch_fault  out  1  high when a fetch timed out; see Optional Feature.

Behaviour:
- Reset (CLB=1, asynchronous):
  - state=FETCH, PC=0, IR=0, timeout counter=0.
  - imem_req=0, instr_valid=0, halted=0, fetch_fault=0.
  - Reset mid-fetch abandons the request; a late ack is ignored.
- After reset is released, the first FETCH cycle raises imem_req.
- FSM states:
  - FETCH: imem_req=1, imem_addr=PC. On imem_ack=1, IR<=imem_rdata and go to EXEC. With ack=0, remain in FETCH, holding req and addr stable.
  - EXEC, exactly 1 cycle: instr_valid=1; Opcode/Operand stable from IR. This gives the controller one edge to register its outputs. Go to UPDATE.
  - UPDATE, exactly 1 cycle: sample IncPC, LoadPC and SelPC, with priority:
    1. Opcode=4'hF → HALT, PC unchanged.
    2. LoadPC=1 → PC<=SelPC ? reg_target : Operand.
    3. IncPC=1 → PC<=PC+1.
    4. Otherwise (not-taken conditional jump, or opcode 0/9/E) → PC<=PC+1.
    Then go to FETCH.
  - HALT: imem_req=0, halted=1. Leave only via CLB.
- Latency: a zero-wait memory (ack in the cycle after req) gives 4 cycles per instruction: FETCH, ack-FETCH, EXEC, UPDATE.
- PC arithmetic is modulo 2^ADDR_W: PC=all-ones plus 1 wraps to 0. Loads are width-exact; no sign extension.
- imem_ack outside FETCH is ignored; no state change.
- LoadPC=1 and IncPC=1 together in UPDATE: the load wins.
- Opcode/Operand change only on IR load, so they are stable from EXEC through the next fetch ack.
- instr_valid never asserts in FETCH or HALT.
- pc updates only in UPDATE.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter increments each FETCH cycle with ack=0 and clears on ack or state exit.
  - When the counter reaches TIMEOUT_CYCLES: drop imem_req, set fetch_fault=1 (sticky until CLB), go to HALT.
  - An ack arriving in the same cycle the limit is reached wins: normal fetch, no fault.
- Undefined: FETCH waits indefinitely; fetch_fault is tied to 0.

Test Plan:
- Reset release, memory acks after 1 cycle with 12'h1_05, controller returns IncPC=1 → imem_addr=0, Opcode=1, Operand=8'h05, instr_valid one pulse, next imem_addr=1, 4 cycles per instruction.
- Instruction 12'h7_3C, controller LoadPC=1, SelPC=0 → next fetch address 8'h3C. Instruction 12'h6_00, LoadPC=1, SelPC=1, reg_target=8'hA7 → next address 8'hA7.
- Not-taken jump: Opcode=8, LoadPC=0, IncPC=0 at PC=8'h10 → next address 8'h11. PC=8'hFF with IncPC=1 → next address 8'h00.
- Opcode 4'hF fetched at PC=8'h20 → halted=1, imem_req stays 0 for 20 cycles, pc=8'h20. Pulse CLB → pc=0, halted=0, fetch resumes.
- Ack delayed 6 cycles → req and addr stable throughout, IR unchanged until ack. Assert CLB in cycle 3 of the wait → req drops immediately, a late ack is ignored, and refetch starts from address 0.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=15 and no ack → fetch_fault=1 and halted=1 after 15 wait cycles. Ack exactly at cycle 15 → no fault.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches over req/ack, sequences FETCH->EXEC->UPDATE.
// Latency: 4 cycles per instruction with a zero-wait memory (FETCH, ack-FETCH, EXEC, UPDATE).
// Backpressure: FETCH holds req/addr until ack; FETCH_TIMEOUT_EN optionally aborts a stuck fetch into HALT.
module fetch_unit #(
    parameter int ADDR_W         = 8,
    parameter int INSTR_W        = 12,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               CLB,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    input  logic               IncPC,
    input  logic               LoadPC,
    input  logic               SelPC,
    input  logic [ADDR_W-1:0]  reg_target,
    output logic [3:0]         Opcode,
    output logic [ADDR_W-1:0]  Operand,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               fetch_fault
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_UPDATE = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc_q, pc_nxt;
    logic [INSTR_W-1:0] ir_q, ir_nxt;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               fault_q, fault_nxt;
`endif

    // State, PC, IR (and wait counter / sticky fault) registers; CLB abandons any fetch in flight.
    always_ff @(posedge clk or posedge CLB) begin
        if (CLB) begin
            state   <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            ir_q    <= ir_nxt;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= cnt_nxt;
            fault_q <= fault_nxt;
`endif
        end
    end

    // Next-state, IR capture and PC update; UPDATE priority is HALT > load > increment > fall-through.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_nxt   = '0;
        fault_nxt = fault_q;
`endif
        case (state)
            S_FETCH: begin
                // An ack in the same cycle the limit is reached still wins.
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = S_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = S_HALT;
                    fault_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_EXEC: begin
                // Controller registers its decision on this edge; IR is already stable.
                state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                if (Opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_FETCH;
                    if (LoadPC) begin
                        pc_nxt = SelPC ? reg_target : Operand;
                    end else if (IncPC) begin
                        pc_nxt = pc_q + ADDR_W'(1);
                    end else begin
                        // Not-taken conditional jump or non-branch opcode: sequential flow.
                        pc_nxt = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Request is gated by CLB so it drops the moment reset asserts mid-fetch.
    assign imem_req    = (state == S_FETCH) && !CLB;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign Opcode      = ir_q[INSTR_W-1 -: 4];
    assign Operand     = ir_q[ADDR_W-1:0];
    assign instr_valid = (state == S_EXEC);
    assign halted      = (state == S_HALT);

`ifdef FETCH_TIMEOUT_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam int AW = 8;
    localparam int IW = 12;

    logic          clk = 1'b0;
    logic          CLB;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          imem_ack;
    logic          IncPC, LoadPC, SelPC;
    logic [AW-1:0] reg_target;
    logic [3:0]    Opcode;
    logic [AW-1:0] Operand;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;
    logic          fetch_fault;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .CLB(CLB),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .IncPC(IncPC), .LoadPC(LoadPC), .SelPC(SelPC), .reg_target(reg_target),
        .Opcode(Opcode), .Operand(Operand), .instr_valid(instr_valid),
        .pc(pc), .halted(halted), .fetch_fault(fetch_fault)
    );

    // Instruction memory model: automatic (acks after ack_delay request cycles) or manual drive.
    logic [IW-1:0] mem [0:255];
    logic          mem_auto;
    int            ack_delay;
    int            wcnt;
    logic          a_ack;
    logic [IW-1:0] a_rdata;
    logic          m_ack;
    logic [IW-1:0] m_rdata;

    assign imem_ack   = mem_auto ? a_ack : m_ack;
    assign imem_rdata = mem_auto ? a_rdata : m_rdata;

    always @(posedge clk or posedge CLB) begin
        if (CLB) begin
            a_ack   <= 1'b0;
            a_rdata <= '0;
            wcnt    <= 0;
        end else if (a_ack) begin
            a_ack <= 1'b0;
            wcnt  <= 0;
        end else if (mem_auto && imem_req) begin
            if (wcnt + 1 >= ack_delay) begin
                a_ack   <= 1'b1;
                a_rdata <= mem[imem_addr];
                wcnt    <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    typedef struct {
        logic [7:0]  cur;
        logic [11:0] instr;
        logic        inc;
        logic        ld;
        logic        sel;
        logic [7:0]  rt;
        logic [3:0]  op;
        logic [7:0]  opnd;
        logic [7:0]  nxt;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] opnd;
        logic [7:0] cur;
        logic [7:0] nxt;
    } exp_t;

    vec_t vecs[10];
    exp_t sbq[$];
    int   last_vcyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input bit check_gap);
        bit   got;
        exp_t e;
        mem[v.cur] = v.instr;
        IncPC      = v.inc;
        LoadPC     = v.ld;
        SelPC      = v.sel;
        reg_target = v.rt;
        sbq.push_back('{v.op, v.opnd, v.cur, v.nxt});
        wait_valid(40, got);
        if (!got) begin
            chk("valid_timeout", 32'd0, 32'd1);
            void'(sbq.pop_front());
            return;
        end
        e = sbq.pop_front();
        chk("opcode", 32'(Opcode), 32'(e.op));
        chk("operand", 32'(Operand), 32'(e.opnd));
        chk("pc_exec", 32'(pc), 32'(e.cur));
        if (check_gap) chk("cycles_per_instr", 32'(cyc - last_vcyc), 32'd4);
        last_vcyc = cyc;
        @(negedge clk);
        chk("valid_one_pulse", 32'(instr_valid), 32'd0);
        chk("pc_in_update", 32'(pc), 32'(e.cur));
        @(negedge clk);
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_addr", 32'(imem_addr), 32'(e.nxt));
        chk("opcode_hold", 32'(Opcode), 32'(e.op));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit stable, req_seen, valid_seen;
        int n;

        vecs[0] = '{8'h00, 12'h105, 1'b1, 1'b0, 1'b0, 8'h00, 4'h1, 8'h05, 8'h01};
        vecs[1] = '{8'h01, 12'h73C, 1'b0, 1'b1, 1'b0, 8'h00, 4'h7, 8'h3C, 8'h3C};
        vecs[2] = '{8'h3C, 12'h600, 1'b0, 1'b1, 1'b1, 8'hA7, 4'h6, 8'h00, 8'hA7};
        vecs[3] = '{8'hA7, 12'h810, 1'b0, 1'b1, 1'b0, 8'h00, 4'h8, 8'h10, 8'h10};
        vecs[4] = '{8'h10, 12'h855, 1'b0, 1'b0, 1'b0, 8'h00, 4'h8, 8'h55, 8'h11};
        vecs[5] = '{8'h11, 12'h7FF, 1'b0, 1'b1, 1'b0, 8'h33, 4'h7, 8'hFF, 8'hFF};
        vecs[6] = '{8'hFF, 12'h100, 1'b1, 1'b0, 1'b0, 8'h00, 4'h1, 8'h00, 8'h00};
        vecs[7] = '{8'h00, 12'h0C3, 1'b1, 1'b1, 1'b1, 8'h30, 4'h0, 8'hC3, 8'h30};
        vecs[8] = '{8'h30, 12'h9AB, 1'b0, 1'b0, 1'b0, 8'h00, 4'h9, 8'hAB, 8'h31};
        vecs[9] = '{8'h31, 12'hE01, 1'b0, 1'b1, 1'b1, 8'h20, 4'hE, 8'h01, 8'h20};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        CLB = 1'b1;
        IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0; reg_target = '0;
        mem_auto = 1'b1; ack_delay = 1; m_ack = 1'b0; m_rdata = '0;
        last_vcyc = 0;

        // Reset state.
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_opcode", 32'(Opcode), 32'd0);
        @(negedge clk); @(negedge clk);
        CLB = 1'b0;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'd0);

        // Table-driven instruction stream with a zero-wait memory.
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i > 0);

        // HALT at 0x20: LoadPC also asserted, halt must still win and pc must hold.
        mem[8'h20] = 12'hF00;
        IncPC = 1'b0; LoadPC = 1'b1; SelPC = 1'b0;
        wait_valid(40, got);
        chk("halt_valid_seen", 32'(got), 32'd1);
        chk("halt_opcode", 32'(Opcode), 32'hF);
        req_seen = 1'b0; valid_seen = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            req_seen   = req_seen | imem_req;
            valid_seen = valid_seen | instr_valid;
        end
        chk("halted", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(req_seen), 32'd0);
        chk("halt_no_valid", 32'(valid_seen), 32'd0);
        chk("halt_pc", 32'(pc), 32'h20);
        LoadPC = 1'b0;
        CLB = 1'b1;
        #1;
        chk("clb_pc", 32'(pc), 32'd0);
        chk("clb_halted", 32'(halted), 32'd0);
        chk("clb_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        CLB = 1'b0;
        #1;
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", 32'(imem_addr), 32'd0);

        // Ack delayed 6 cycles: req/addr/IR stable throughout the wait.
        ack_delay = 6;
        mem[0] = 12'h234;
        IncPC = 1'b1;
        stable = 1'b1; n = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                got = 1'b1;
                break;
            end
            n++;
            if (!(imem_req && imem_addr == 8'h00 && Opcode == 4'h0 && Operand == 8'h00)) stable = 1'b0;
        end
        chk("delay_valid_seen", 32'(got), 32'd1);
        chk("delay_stable", 32'(stable), 32'd1);
        chk("delay_wait_cycles", 32'(n), 32'd6);
        chk("delay_opcode", 32'(Opcode), 32'h2);
        chk("delay_operand", 32'(Operand), 32'h34);
        mem_auto = 1'b0;
        ack_delay = 1;
        @(negedge clk);
        @(negedge clk);
        CLB = 1'b1;
        @(negedge clk);
        CLB = 1'b0;

        // Reset in cycle 3 of a wait: req drops at once, an ack during reset is ignored.
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("wait_req", 32'(imem_req), 32'd1);
        CLB = 1'b1;
        #1;
        chk("midfetch_req_drop", 32'(imem_req), 32'd0);
        m_ack = 1'b1; m_rdata = 12'hFFF;
        @(negedge clk);
        m_ack = 1'b0;
        chk("late_ack_ir", 32'(Opcode), 32'd0);
        chk("late_ack_halted", 32'(halted), 32'd0);
        CLB = 1'b0;
        #1;
        chk("refetch_req", 32'(imem_req), 32'd1);
        chk("refetch_addr", 32'(imem_addr), 32'd0);

        // Ack held high through EXEC and UPDATE must not disturb IR or state.
        m_ack = 1'b1; m_rdata = 12'h344;
        IncPC = 1'b1; LoadPC = 1'b0;
        @(negedge clk);
        chk("man_valid", 32'(instr_valid), 32'd1);
        chk("man_opcode", 32'(Opcode), 32'h3);
        chk("man_operand", 32'(Operand), 32'h44);
        m_rdata = 12'hFFF;
        @(negedge clk);
        chk("stray_ack_update", 32'(instr_valid), 32'd0);
        @(negedge clk);
        m_ack = 1'b0;
        chk("stray_ack_addr", 32'(imem_addr), 32'h01);
        chk("stray_ack_opcode", 32'(Opcode), 32'h3);
        chk("stray_ack_halted", 32'(halted), 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // No ack: fault and halt after 15 wait cycles.
        CLB = 1'b1;
        @(negedge clk);
        CLB = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted) break;
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd14);
        chk("tmo_halted", 32'(halted), 32'd1);
        chk("tmo_fault", 32'(fetch_fault), 32'd1);
        chk("tmo_req", 32'(imem_req), 32'd0);
        CLB = 1'b1;
        #1;
        chk("tmo_clb_fault", 32'(fetch_fault), 32'd0);
        @(negedge clk);
        CLB = 1'b0;
        // Ack in the 15th wait cycle wins over the limit.
        for (int i = 0; i < 14; i++) @(negedge clk);
        m_ack = 1'b1; m_rdata = 12'h105;
        @(negedge clk);
        m_ack = 1'b0;
        chk("tmo_edge_valid", 32'(instr_valid), 32'd1);
        chk("tmo_edge_fault", 32'(fetch_fault), 32'd0);
        chk("tmo_edge_opcode", 32'(Opcode), 32'h1);
`else
        // No ack: fetch waits indefinitely without fault.
        for (int i = 0; i < 30; i++) @(negedge clk);
        chk("nowait_halted", 32'(halted), 32'd0);
        chk("nowait_fault", 32'(fetch_fault), 32'd0);
        chk("nowait_req", 32'(imem_req), 32'd1);
        chk("nowait_addr", 32'(imem_addr), 32'h01);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
